// File: rtl/fuzz_program_loader_pkg.sv
// Shared opcode constants, loader state encoding and load error codes for the
// fuzz program loader.
package fuzz_program_loader_pkg;

  localparam logic [7:0] OPCODE_HALT = 8'h01;
  localparam logic [7:0] OPCODE_PNEW = 8'h02;
  localparam logic [7:0] OPCODE_SEND = 8'h03;
  localparam logic [7:0] OPCODE_RECV = 8'h04;
  localparam logic [7:0] OPCODE_JMP  = 8'h05;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RECV  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    LOAD_ERR_NONE     = 2'b00,
    LOAD_ERR_PARTIAL  = 2'b01,
    LOAD_ERR_OVERFLOW = 2'b10,
    LOAD_ERR_EMPTY    = 2'b11
  } load_err_t;

  function automatic logic is_halt(input logic [31:0] word);
    return word[31:24] == OPCODE_HALT;
  endfunction

endpackage

// File: rtl/fuzz_word_packer.sv
// Packs accepted bytes into a 32-bit word, opcode byte in [31:24]; the full
// word and its done strobe are combinational on the 4th byte's handshake.
module fuzz_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  byte_cnt;
  logic [23:0] hi_bytes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      hi_bytes <= 24'h0;
    end else if (clr) begin
      byte_cnt <= 2'd0;
      hi_bytes <= 24'h0;
    end else if (accept) begin
      case (byte_cnt)
        2'd0:    hi_bytes[23:16] <= data;
        2'd1:    hi_bytes[15:8]  <= data;
        2'd2:    hi_bytes[7:0]   <= data;
        default: ;
      endcase
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // The last byte lands straight in [7:0] so the write can issue one cycle later.
  assign word      = {hi_bytes, data};
  assign word_done = accept && (byte_cnt == 2'd3);

endmodule

// File: rtl/fuzz_program_loader.sv
// Clears instruction memory, streams a byte program into it word by word, then
// pulses start; s_ready is high only while receiving, writes land 1 cycle after the 4th byte.
module fuzz_program_loader
  import fuzz_program_loader_pkg::*;
#(
  parameter int MAX_INSTRUCTIONS = 256,
  parameter int ADDR_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   prog_len,
  output logic              halt_seen,
  output logic              load_done,
  output logic              start,
  output logic [1:0]        load_err
);

  localparam logic [ADDR_W:0] IDX_FULL = (ADDR_W+1)'(MAX_INSTRUCTIONS);

  state_t          state;
  logic [ADDR_W:0] clr_cnt;
  logic [ADDR_W:0] word_idx;
  logic            done_pend;

  logic        accept;
  logic        overflow;
  logic        pk_accept;
  logic        pk_clr;
  logic [31:0] pk_word;
  logic        pk_done;

  assign accept    = s_valid && s_ready;
  assign overflow  = accept && (word_idx == IDX_FULL);
  assign pk_accept = accept && !overflow;
  assign pk_clr    = (state == ST_CLEAR);

  fuzz_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pk_clr),
    .accept    (pk_accept),
    .data      (s_data),
    .word      (pk_word),
    .word_done (pk_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      word_idx   <= '0;
      done_pend  <= 1'b0;
      s_ready    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      prog_len   <= '0;
      halt_seen  <= 1'b0;
      load_done  <= 1'b0;
      start      <= 1'b0;
      load_err   <= LOAD_ERR_NONE;
    end else begin
      imem_we <= 1'b0;
      start   <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == IDX_FULL) begin
            state   <= ST_RECV;
            s_ready <= 1'b1;
          end else begin
            imem_we    <= 1'b1;
            imem_addr  <= clr_cnt[ADDR_W-1:0];
            imem_wdata <= 32'h0;
            clr_cnt    <= clr_cnt + 1'b1;
          end
        end
        ST_RECV: begin
          if (done_pend) begin
            // prog_len already reflects the final word written last cycle.
            done_pend <= 1'b0;
            if (prog_len == '0) begin
              state    <= ST_ERR;
              load_err <= LOAD_ERR_EMPTY;
            end else begin
              state     <= ST_DONE;
              load_done <= 1'b1;
              start     <= 1'b1;
            end
          end else if (overflow) begin
            state    <= ST_ERR;
            load_err <= LOAD_ERR_OVERFLOW;
            s_ready  <= 1'b0;
          end else if (accept) begin
            if (pk_done) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx[ADDR_W-1:0];
              imem_wdata <= pk_word;
              word_idx   <= word_idx + 1'b1;
              if (pk_word != 32'h0) prog_len <= word_idx + 1'b1;
              if (is_halt(pk_word)) halt_seen <= 1'b1;
              if (s_last) begin
                s_ready   <= 1'b0;
                done_pend <= 1'b1;
              end
            end else if (s_last) begin
              state    <= ST_ERR;
              load_err <= LOAD_ERR_PARTIAL;
              s_ready  <= 1'b0;
            end
          end
        end
        default: begin
          if (reload) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            word_idx  <= '0;
            done_pend <= 1'b0;
            prog_len  <= '0;
            halt_seen <= 1'b0;
            load_done <= 1'b0;
            load_err  <= LOAD_ERR_NONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fuzz_program_loader.sv
// Directed-plus-random bench for fuzz_program_loader against a word-level
// reference model of the loading rules.
module tb_fuzz_program_loader;
  import fuzz_program_loader_pkg::*;

  localparam int MAXI = 256;
  localparam int AW   = 8;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = 8'h0;
  logic          s_last = 1'b0;
  logic          reload = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   prog_len;
  logic          halt_seen;
  logic          load_done;
  logic          start;
  logic [1:0]    load_err;

  always #5 clk = ~clk;

  fuzz_program_loader #(.MAX_INSTRUCTIONS(MAXI), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .prog_len   (prog_len),
    .halt_seen  (halt_seen),
    .load_done  (load_done),
    .start      (start),
    .load_err   (load_err)
  );

  int tests = 0;
  int fails = 0;

  logic [39:0] wr_q[$];
  int          start_cnt = 0;
  int          ready_overlap = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_we) begin
        wr_q.push_back({imem_addr, imem_wdata});
        if (s_ready) ready_overlap++;
      end
      if (start) start_cnt++;
    end
  end

  // Reference model results
  logic [31:0] exp_words[$];
  int          exp_acc;
  logic [AW:0] exp_len;
  logic        exp_halt;
  logic [1:0]  exp_err;
  logic        exp_start;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_prog(input byte_q_t b);
    int n;
    int nw;
    logic [31:0] w;
    n = b.size();
    exp_words.delete();
    if (n > 4*MAXI) begin
      exp_acc = 4*MAXI + 1;
      exp_err = 2'b10;
      nw = MAXI;
    end else begin
      exp_acc = n;
      nw = n / 4;
      exp_err = (n % 4 != 0) ? 2'b01 : 2'b00;
    end
    exp_len = '0;
    exp_halt = 1'b0;
    for (int k = 0; k < nw; k++) begin
      w = {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]};
      exp_words.push_back(w);
      if (w != 32'h0) exp_len = (AW+1)'(k + 1);
      if (w[31:24] == OPCODE_HALT) exp_halt = 1'b1;
    end
    if (exp_err == 2'b00 && exp_len == '0) exp_err = 2'b11;
    exp_start = (exp_err == 2'b00);
  endtask

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t b;
    for (int k = 0; k < n; k++) b.push_back(8'($urandom_range(0, 255)));
    return b;
  endfunction

  function automatic byte_q_t rand_prog(input int nw);
    byte_q_t b;
    for (int k = 0; k < nw; k++) begin
      int kind;
      kind = $urandom_range(0, 5);
      for (int j = 0; j < 4; j++) begin
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (kind == 0) v = 8'h0;
        else if (kind == 1 && j == 0) v = OPCODE_HALT;
        b.push_back(v);
      end
    end
    return b;
  endfunction

  // Called on a falling edge; leaves on a falling edge with inputs idle.
  task automatic stream(input byte_q_t b, input bit with_last, input bit gaps, output int acc);
    int i;
    int cyc;
    bit gap;
    i = 0;
    cyc = 0;
    while (i < b.size() && cyc < 3000) begin
      if (!s_ready && (load_done || load_err != 2'b00)) break;
      gap = gaps && ($urandom_range(0, 3) == 0);
      s_valid = !gap;
      s_data  = b[i];
      s_last  = with_last && (i == b.size() - 1);
      if (!gap && s_ready) i++;
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    acc = i;
  endtask

  task automatic check_zero(input string tag);
    check(tag, {s_ready, imem_we, imem_addr, imem_wdata, prog_len, halt_seen,
                load_done, start, load_err}, 64'h0);
  endtask

  task automatic check_clear(input string tag);
    int cyc;
    int bad;
    cyc = 0;
    bad = 0;
    wr_q.delete();
    ready_overlap = 0;
    while (!s_ready && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".ready_cycle"}, 64'(cyc), 64'd257);
    check({tag, ".writes"}, 64'(wr_q.size()), 64'(MAXI));
    foreach (wr_q[k]) if (wr_q[k] !== {8'(k), 32'h0}) bad++;
    check({tag, ".bad_writes"}, 64'(bad), 64'd0);
    check({tag, ".ready_overlap"}, 64'(ready_overlap), 64'd0);
    check({tag, ".status"}, {prog_len, halt_seen, load_done, load_err}, 64'h0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic run_load(input string tag, input byte_q_t b, input bit gaps);
    int acc;
    int w;
    int bad;
    wr_q.delete();
    start_cnt = 0;
    model_prog(b);
    stream(b, 1'b1, gaps, acc);
    w = 0;
    while (!(load_done || load_err != 2'b00) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, ".settled"}, 64'(w < 20), 64'd1);
    repeat (3) @(negedge clk);
    check({tag, ".accepted"}, 64'(acc), 64'(exp_acc));
    check({tag, ".nwrites"}, 64'(wr_q.size()), 64'(exp_words.size()));
    bad = 0;
    foreach (exp_words[k])
      if (k >= wr_q.size() || wr_q[k] !== {8'(k), exp_words[k]}) bad++;
    check({tag, ".bad_words"}, 64'(bad), 64'd0);
    check({tag, ".prog_len"}, 64'(prog_len), 64'(exp_len));
    check({tag, ".halt_seen"}, 64'(halt_seen), 64'(exp_halt));
    check({tag, ".load_err"}, 64'(load_err), 64'(exp_err));
    check({tag, ".load_done"}, 64'(load_done), 64'(exp_start));
    check({tag, ".starts"}, 64'(start_cnt), 64'(exp_start));
    check({tag, ".ready_low"}, 64'(s_ready), 64'd0);
  endtask

  initial begin
    byte_q_t b;
    int acc;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    check_clear("clear0");

    b = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
          OPCODE_HALT, 8'h00, 8'h00, 8'h00};
    run_load("progA", b, 1'b0);
    check("progA.len_direct", 64'(prog_len), 64'd3);
    check("progA.halt_direct", 64'(halt_seen), 64'd1);

    do_reload();
    check_clear("clear1");

    // reload must be ignored while receiving
    do_reload();
    check("reload_in_recv", {s_ready, imem_we, load_done}, 64'b100);

    run_load("partial", rand_bytes(5), 1'b1);
    check("partial.err_direct", 64'(load_err), 64'd1);

    do_reload();
    check_clear("clear2");
    run_load("overflow", rand_bytes(1028), 1'b0);
    check("overflow.err_direct", 64'(load_err), 64'd2);

    do_reload();
    check_clear("clear3");
    run_load("ovf_last", rand_bytes(1025), 1'b0);

    do_reload();
    check_clear("clear4");
    b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load("empty", b, 1'b0);
    check("empty.err_direct", 64'(load_err), 64'd3);

    for (int r = 0; r < 4; r++) begin
      do_reload();
      check_clear($sformatf("clear_r%0d", r));
      run_load($sformatf("rand%0d", r), rand_prog($urandom_range(1, 12)), 1'b1);
    end

    do_reload();
    check_clear("clear5");
    stream(rand_bytes(6), 1'b0, 1'b0, acc);
    check("midrst.accepted", 64'(acc), 64'd6);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrst.reset");
    rst_n = 1'b1;
    check_clear("clear_after_rst");

    b = rand_prog(3);
    b[0] = OPCODE_JMP;
    run_load("post_rst", b, 1'b0);

    do_reload();
    check_clear("clear6");
    b = '{OPCODE_SEND, 8'h11, 8'h22, 8'h33};
    run_load("one_word", b, 1'b0);
    check("one_word.len_direct", 64'(prog_len), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
